// File: rtl/gate_array_pipe_pkg.sv
// Shared types and helpers for the gate_array_pipe logic unit.
// Optional feature macro used by the top: GATE_ARRAY_PIPE_STATS_EN.
package gate_array_pipe_pkg;

  localparam int MAX_NUM_IN = 8;
  localparam int MAX_STAGES = 4;

  typedef enum logic [2:0] {
    GATE_AND  = 3'd0,
    GATE_OR   = 3'd1,
    GATE_XOR  = 3'd2,
    GATE_NAND = 3'd3,
    GATE_NOR  = 3'd4,
    GATE_XNOR = 3'd5,
    GATE_PASS = 3'd6,
    GATE_NOT  = 3'd7
  } gate_op_t;

  // Reduces one bit column (bit b of every operand) with the selected gate.
  // Operations are bitwise, so the full result is this function applied per bit.
  // Positions at or above num_in are ignored.
  function automatic logic gate_reduce(input gate_op_t op,
                                       input logic [MAX_NUM_IN-1:0] operands,
                                       input int num_in);
    logic r_and;
    logic r_or;
    logic r_xor;
    logic result;
    r_and = 1'b1;
    r_or  = 1'b0;
    r_xor = 1'b0;
    for (int k = 0; k < MAX_NUM_IN; k++) begin
      if (k < num_in) begin
        r_and = r_and & operands[k];
        r_or  = r_or  | operands[k];
        r_xor = r_xor ^ operands[k];
      end
    end
    case (op)
      GATE_AND:  result = r_and;
      GATE_OR:   result = r_or;
      GATE_XOR:  result = r_xor;
      GATE_NAND: result = ~r_and;
      GATE_NOR:  result = ~r_or;
      GATE_XNOR: result = ~r_xor;
      GATE_PASS: result = operands[0];
      default:   result = ~operands[0];
    endcase
    return result;
  endfunction

endpackage

// File: rtl/gate_pipe_stage.sv
// One elastic valid/ready register slice carrying {op, data}.
// Ready is combinational: the slice accepts when empty or when its content leaves this cycle.
module gate_pipe_stage
  import gate_array_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  gate_op_t         in_op,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output gate_op_t         out_op,
  output logic [WIDTH-1:0] out_data
);

  logic             valid_q;
  gate_op_t         op_q;
  logic [WIDTH-1:0] data_q;

  assign in_ready  = ~valid_q | out_ready;
  assign out_valid = valid_q;
  assign out_op    = op_q;
  assign out_data  = data_q;

  // Load a new beat whenever the slot is free; otherwise hold contents stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      op_q    <= GATE_AND;
      data_q  <= '0;
    end else if (in_ready) begin
      valid_q <= in_valid;
      if (in_valid) begin
        op_q   <= in_op;
        data_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/gate_array_pipe.sv
// Pipelined bitwise gate unit: NUM_IN operands reduced by a selectable gate,
// then carried through STAGES elastic register slices.
// Define GATE_ARRAY_PIPE_STATS_EN to add the txn_count output-transfer counter.
module gate_array_pipe
  import gate_array_pipe_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2,
  parameter int STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              in_op,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2:0]              out_op,
  output logic [WIDTH-1:0]        out_data
`ifdef GATE_ARRAY_PIPE_STATS_EN
  ,
  output logic [31:0]             txn_count
`endif
);

  logic [WIDTH-1:0] reduced;

  logic             valid_chain [STAGES+1];
  logic             ready_chain [STAGES+1];
  gate_op_t         op_chain    [STAGES+1];
  logic [WIDTH-1:0] data_chain  [STAGES+1];

  // Combinational reduction ahead of stage 1, one bit column at a time.
  always_comb begin
    logic [MAX_NUM_IN-1:0] column;
    reduced = '0;
    for (int b = 0; b < WIDTH; b++) begin
      column = '0;
      for (int k = 0; k < NUM_IN; k++) begin
        column[k] = in_data[k*WIDTH + b];
      end
      reduced[b] = gate_reduce(gate_op_t'(in_op), column, NUM_IN);
    end
  end

  assign valid_chain[0]      = in_valid;
  assign op_chain[0]         = gate_op_t'(in_op);
  assign data_chain[0]       = reduced;
  assign in_ready            = ready_chain[0];
  assign ready_chain[STAGES] = out_ready;
  assign out_valid           = valid_chain[STAGES];
  assign out_op              = op_chain[STAGES];
  assign out_data            = data_chain[STAGES];

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    gate_pipe_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (valid_chain[s]),
      .in_ready (ready_chain[s]),
      .in_op    (op_chain[s]),
      .in_data  (data_chain[s]),
      .out_valid(valid_chain[s+1]),
      .out_ready(ready_chain[s+1]),
      .out_op   (op_chain[s+1]),
      .out_data (data_chain[s+1])
    );
  end

`ifdef GATE_ARRAY_PIPE_STATS_EN
  // Count every output handshake; wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_count <= '0;
    end else if (out_valid && out_ready) begin
      txn_count <= txn_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gate_array_pipe.sv
// Directed self-checking bench for gate_array_pipe using three parameterisations:
// A = (8,2,2), B = (8,4,2), C = (8,2,3). Stats checks build with GATE_ARRAY_PIPE_STATS_EN.
module tb_gate_array_pipe;

  logic clk;
  logic rst_n;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [2:0]  a_in_op, a_out_op;
  logic [15:0] a_in_data;
  logic [7:0]  a_out_data;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [2:0]  b_in_op, b_out_op;
  logic [31:0] b_in_data;
  logic [7:0]  b_out_data;

  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [2:0]  c_in_op, c_out_op;
  logic [15:0] c_in_data;
  logic [7:0]  c_out_data;

`ifdef GATE_ARRAY_PIPE_STATS_EN
  logic [31:0] a_txn_count, b_txn_count, c_txn_count;
`endif

  int checks = 0;
  int errors = 0;

  gate_array_pipe #(.WIDTH(8), .NUM_IN(2), .STAGES(2)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_op(a_in_op), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_op(a_out_op), .out_data(a_out_data)
`ifdef GATE_ARRAY_PIPE_STATS_EN
    , .txn_count(a_txn_count)
`endif
  );

  gate_array_pipe #(.WIDTH(8), .NUM_IN(4), .STAGES(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_op(b_in_op), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_op(b_out_op), .out_data(b_out_data)
`ifdef GATE_ARRAY_PIPE_STATS_EN
    , .txn_count(b_txn_count)
`endif
  );

  gate_array_pipe #(.WIDTH(8), .NUM_IN(2), .STAGES(3)) dut_c (
    .clk(clk), .rst_n(rst_n),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_op(c_in_op), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_op(c_out_op), .out_data(c_out_data)
`ifdef GATE_ARRAY_PIPE_STATS_EN
    , .txn_count(c_txn_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and land a little after the rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    logic [7:0] exp_ops [8];
    int accepted;
    int seen;
    int budget;
    exp_ops[0] = 8'h30; exp_ops[1] = 8'hFC; exp_ops[2] = 8'hCC; exp_ops[3] = 8'hCF;
    exp_ops[4] = 8'h03; exp_ops[5] = 8'h33; exp_ops[6] = 8'hF0; exp_ops[7] = 8'h0F;

    rst_n = 1'b0;
    a_in_valid = 0; a_out_ready = 1; a_in_op = 0; a_in_data = '0;
    b_in_valid = 0; b_out_ready = 1; b_in_op = 0; b_in_data = '0;
    c_in_valid = 0; c_out_ready = 1; c_in_op = 0; c_in_data = '0;

    // Reset state
    step(); step();
    check_output("reset_out_valid", {31'd0, a_out_valid}, 32'd0);
    check_output("reset_out_data", {24'd0, a_out_data}, 32'd0);
    check_output("reset_out_op", {29'd0, a_out_op}, 32'd0);
    rst_n = 1'b1;
    step();
    check_output("release_in_ready", {31'd0, a_in_ready}, 32'd1);

    // All eight ops back to back on A=F0, B=3C; result of beat i appears one step later
    a_in_valid = 1;
    for (int i = 0; i < 8; i++) begin
      a_in_op = 3'(i);
      a_in_data = {8'h3C, 8'hF0};
      step();
      check_output("ops_in_ready", {31'd0, a_in_ready}, 32'd1);
      if (i >= 1) begin
        check_output("ops_out_valid", {31'd0, a_out_valid}, 32'd1);
        check_output("ops_out_data", {24'd0, a_out_data}, {24'd0, exp_ops[i-1]});
        check_output("ops_out_op", {29'd0, a_out_op}, 32'(i - 1));
      end
    end
    a_in_valid = 0;
    step();
    check_output("ops_last_data", {24'd0, a_out_data}, {24'd0, exp_ops[7]});
    check_output("ops_last_op", {29'd0, a_out_op}, 32'd7);
    step();
    check_output("ops_drained", {31'd0, a_out_valid}, 32'd0);

    // Four-operand reductions
    b_in_valid = 1; b_in_op = 3'd0; b_in_data = {8'h1F, 8'h3F, 8'h0F, 8'hFF};
    step(); b_in_valid = 0; step();
    check_output("n4_and", {23'd0, b_out_valid, b_out_data}, {23'd0, 1'b1, 8'h0F});
    b_in_valid = 1; b_in_op = 3'd2; b_in_data = {8'h08, 8'h04, 8'h02, 8'h01};
    step(); b_in_valid = 0; step();
    check_output("n4_xor", {23'd0, b_out_valid, b_out_data}, {23'd0, 1'b1, 8'h0F});
    b_in_valid = 1; b_in_op = 3'd4;
    step(); b_in_valid = 0; step();
    check_output("n4_nor", {23'd0, b_out_valid, b_out_data}, {23'd0, 1'b1, 8'hF0});

    // 16 back-to-back XOR beats with 8'h55 at full throughput
    a_in_valid = 1; a_in_op = 3'd2; a_out_ready = 1;
    for (int i = 0; i < 16; i++) begin
      a_in_data = {8'h55, 8'(i)};
      #1;
      check_output("b2b_in_ready", {31'd0, a_in_ready}, 32'd1);
      step();
      if (i >= 1) begin
        check_output("b2b_data", {23'd0, a_out_valid, a_out_data}, {23'd0, 1'b1, 8'(i - 1) ^ 8'h55});
      end
    end
    a_in_valid = 0;
    step();
    check_output("b2b_last", {23'd0, a_out_valid, a_out_data}, {23'd0, 1'b1, 8'h0F ^ 8'h55});
    step();

    // Backpressure on the 3-stage pipe: exactly three beats fit
    c_out_ready = 0; c_in_valid = 1; c_in_op = 3'd6;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      c_in_data = {8'h00, 8'h10 + 8'(accepted)};
      #1;
      if (c_in_ready) accepted++;
      step();
    end
    check_output("bp_accepted", 32'(accepted), 32'd3);
    check_output("bp_in_ready", {31'd0, c_in_ready}, 32'd0);
    check_output("bp_hold", {20'd0, c_out_valid, c_out_op, c_out_data}, {20'd0, 1'b1, 3'd6, 8'h10});
    step();
    check_output("bp_stable", {24'd0, c_out_data}, 32'h10);
    c_in_valid = 0; c_out_ready = 1;
    step();
    check_output("drain_1", {23'd0, c_out_valid, c_out_data}, {23'd0, 1'b1, 8'h11});
    step();
    check_output("drain_2", {23'd0, c_out_valid, c_out_data}, {23'd0, 1'b1, 8'h12});
    step();
    check_output("drain_empty", {31'd0, c_out_valid}, 32'd0);

    // Reset mid-stream discards in-flight beats and clears outputs at once
    a_in_valid = 1; a_in_op = 3'd1; a_in_data = 16'hA55A;
    step(); step();
    rst_n = 1'b0;
    #1;
    check_output("midreset_out", {23'd0, a_out_valid, a_out_data}, 32'd0);
    a_in_valid = 0;
    step();
    rst_n = 1'b1;
    step();
    check_output("midreset_in_ready", {31'd0, a_in_ready}, 32'd1);
    step();
    check_output("midreset_no_output", {31'd0, a_out_valid}, 32'd0);

`ifdef GATE_ARRAY_PIPE_STATS_EN
    // Ten output transfers under random stalls
    check_output("stats_after_reset", a_txn_count, 32'd0);
    seen = 0; budget = 0;
    a_in_valid = 1; a_in_op = 3'd0; a_in_data = 16'hFFFF;
    while (seen < 10 && budget < 500) begin
      a_out_ready = 1'($urandom_range(0, 1));
      #1;
      if (a_out_valid && a_out_ready) seen++;
      step();
      budget++;
    end
    a_in_valid = 0; a_out_ready = 0;
    check_output("stats_budget", {31'd0, seen == 10}, 32'd1);
    step();
    check_output("stats_count", a_txn_count, 32'd10);
    rst_n = 1'b0;
    #1;
    check_output("stats_reset", a_txn_count, 32'd0);
    step();
    rst_n = 1'b1;
    step();
`else
    seen = 0; budget = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
